// File: rtl/workgroup_pkg.sv
`default_nettype none
// ============================================================================
// Module      : workgroup_pkg
// Description : Shared types and constants for the workgroup L2 arbiter:
//               slot count, ACP slot index, FSM states and register set.
// Revision    : 1.0 - initial release
// ============================================================================
package workgroup_pkg;

    localparam int unsigned CFG_CPU_MAX          = 4;
    localparam int unsigned CFG_SYSBUS_ADDR_BITS = 32;
    localparam int unsigned CFG_SYSBUS_DATA_BITS = 64;

    // Request slots: cores 0..CFG_CPU_MAX-1, ACP in the last slot.
    localparam int unsigned N             = CFG_CPU_MAX + 1;
    localparam int unsigned SLOT_IDX_BITS = $clog2(N);

    typedef logic [SLOT_IDX_BITS-1:0] slot_idx_t;

    localparam slot_idx_t ACP_SLOT_IDX = slot_idx_t'(CFG_CPU_MAX);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2
    } l2_arb_state_t;

    // Complete arbiter register set; owner/write/addr are the latched request.
    typedef struct packed {
        l2_arb_state_t                   state;
        slot_idx_t                       rr_ptr;
        slot_idx_t                       owner;
        logic                            write;
        logic [CFG_SYSBUS_ADDR_BITS-1:0] addr;
    } l2_arb_regs_t;

    localparam l2_arb_regs_t c_l2_arb_regs_reset = '{
        state  : IDLE,
        rr_ptr : '0,
        owner  : '0,
        write  : 1'b0,
        addr   : '0
    };

    // Next slot index, wrapping N-1 -> 0.
    function automatic slot_idx_t slot_inc(input slot_idx_t s);
        return (s == slot_idx_t'(N - 1)) ? '0 : s + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wg_l2_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wg_l2_arbiter_if
// Description : Request slots plus downstream L2 bus of the workgroup arbiter.
//               Signal directions are named from the arbiter's point of view.
// Revision    : 1.0 - initial release
// ============================================================================
interface wg_l2_arbiter_if;
    import workgroup_pkg::*;

    logic [N-1:0]                           i_req_valid;
    logic [N-1:0]                           i_req_write;
    logic [N-1:0][CFG_SYSBUS_ADDR_BITS-1:0] i_req_addr;
    logic [N-1:0]                           o_req_ready;
    logic [N-1:0]                           o_resp_valid;
    logic [CFG_SYSBUS_DATA_BITS-1:0]        o_resp_data;

    logic                                   o_l2_req_valid;
    logic                                   o_l2_req_write;
    logic [CFG_SYSBUS_ADDR_BITS-1:0]        o_l2_req_addr;
    slot_idx_t                              o_l2_req_src;
    logic                                   i_l2_req_ready;
    logic                                   i_l2_resp_valid;
    logic [CFG_SYSBUS_DATA_BITS-1:0]        i_l2_resp_data;

    // Arbiter side.
    modport slave (
        input  i_req_valid, i_req_write, i_req_addr,
        output o_req_ready, o_resp_valid, o_resp_data,
        output o_l2_req_valid, o_l2_req_write, o_l2_req_addr, o_l2_req_src,
        input  i_l2_req_ready, i_l2_resp_valid, i_l2_resp_data
    );

    // Requesters plus L2 side.
    modport master (
        output i_req_valid, i_req_write, i_req_addr,
        input  o_req_ready, o_resp_valid, o_resp_data,
        input  o_l2_req_valid, o_l2_req_write, o_l2_req_addr, o_l2_req_src,
        output i_l2_req_ready, i_l2_resp_valid, i_l2_resp_data
    );

endinterface
`default_nettype wire

// File: rtl/wg_l2_arbiter_rr_prio_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_prio_pick
// Description : Round-robin priority search: first valid slot at or above
//               the pointer, wrapping from N-1 back to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_prio_pick
    import workgroup_pkg::*;
(
    input  logic [N-1:0] i_valid,
    input  slot_idx_t    i_ptr,
    output slot_idx_t    o_idx,
    output logic         o_found
);

    // Scan offsets from farthest to nearest so the nearest valid slot wins.
    always_comb begin
        int w_j;
        w_j     = 0;
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            w_j = int'(i_ptr) + i;
            if (w_j >= int'(N)) begin
                w_j = w_j - int'(N);
            end
            if (i_valid[slot_idx_t'(w_j)]) begin
                o_idx   = slot_idx_t'(w_j);
                o_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wg_l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wg_l2_arbiter
// Description : Single-outstanding L2 request arbiter for the core slots and
//               the ACP slot. Round-robin grant, optional strict ACP priority.
// Revision    : 1.0 - initial release
// ============================================================================
module wg_l2_arbiter
    import workgroup_pkg::*;
#(
    parameter bit acp_priority = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_nrst,
    wg_l2_arbiter_if.slave  bus
);

    l2_arb_regs_t                    r_regs;
    l2_arb_regs_t                    w_regs_next;
    slot_idx_t                       w_rr_idx;
    logic                            w_rr_found;
    slot_idx_t                       w_winner;

    logic [N-1:0]                    w_req_ready;
    logic [N-1:0]                    w_resp_valid;
    logic [CFG_SYSBUS_DATA_BITS-1:0] w_resp_data;
    logic                            w_l2_req_valid;
    logic                            w_l2_req_write;
    logic [CFG_SYSBUS_ADDR_BITS-1:0] w_l2_req_addr;
    slot_idx_t                       w_l2_req_src;

    rr_prio_pick u_rr_prio_pick (
        .i_valid (bus.i_req_valid),
        .i_ptr   (r_regs.rr_ptr),
        .o_idx   (w_rr_idx),
        .o_found (w_rr_found)
    );

    // A valid ACP always implies w_rr_found, so only the index needs overriding.
    assign w_winner = (acp_priority && bus.i_req_valid[ACP_SLOT_IDX]) ? ACP_SLOT_IDX : w_rr_idx;

    // Register set; asynchronous reset aborts any transaction in flight.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_regs <= c_l2_arb_regs_reset;
        end else begin
            r_regs <= w_regs_next;
        end
    end

    // Next-state and output decode; outputs are zero outside their own state.
    always_comb begin
        w_regs_next    = r_regs;
        w_req_ready    = '0;
        w_resp_valid   = '0;
        w_resp_data    = '0;
        w_l2_req_valid = 1'b0;
        w_l2_req_write = 1'b0;
        w_l2_req_addr  = '0;
        w_l2_req_src   = '0;
        case (r_regs.state)
            IDLE: begin
                if (w_rr_found) begin
                    w_regs_next.owner = w_winner;
                    w_regs_next.write = bus.i_req_write[w_winner];
                    w_regs_next.addr  = bus.i_req_addr[w_winner];
                    w_regs_next.state = REQ;
                end
            end
            REQ: begin
                w_l2_req_valid             = 1'b1;
                w_l2_req_write             = r_regs.write;
                w_l2_req_addr              = r_regs.addr;
                w_l2_req_src               = r_regs.owner;
                w_req_ready[r_regs.owner]  = bus.i_l2_req_ready;
                if (bus.i_l2_req_ready) begin
                    w_regs_next.state = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                w_resp_valid[r_regs.owner] = bus.i_l2_resp_valid;
                w_resp_data                = bus.i_l2_resp_data;
                if (bus.i_l2_resp_valid) begin
                    w_regs_next.state  = IDLE;
                    w_regs_next.rr_ptr = slot_inc(r_regs.owner);
                end
            end
            default: begin
                w_regs_next = c_l2_arb_regs_reset;
            end
        endcase
    end

    assign bus.o_req_ready    = w_req_ready;
    assign bus.o_resp_valid   = w_resp_valid;
    assign bus.o_resp_data    = w_resp_data;
    assign bus.o_l2_req_valid = w_l2_req_valid;
    assign bus.o_l2_req_write = w_l2_req_write;
    assign bus.o_l2_req_addr  = w_l2_req_addr;
    assign bus.o_l2_req_src   = w_l2_req_src;

endmodule
`default_nettype wire

// File: tb/tb_wg_l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wg_l2_arbiter
// Description : Self-checking bench for wg_l2_arbiter; one instance with
//               round-robin ACP, one with strict ACP priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wg_l2_arbiter;
    import workgroup_pkg::*;

    localparam int NS = int'(N);

    logic clk  = 1'b0;
    logic nrst = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_ptr  = 0;
    int m_ptr1 = 0;
    int wait_cnt [NS];
    int max_wait = 0;

    wg_l2_arbiter_if bus0 ();
    wg_l2_arbiter_if bus1 ();

    wg_l2_arbiter #(.acp_priority(1'b0)) dut0 (
        .i_clk  (clk),
        .i_nrst (nrst),
        .bus    (bus0.slave)
    );

    wg_l2_arbiter #(.acp_priority(1'b1)) dut1 (
        .i_clk  (clk),
        .i_nrst (nrst),
        .bus    (bus1.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference rule: strict ACP if enabled, else first valid slot from ptr upward.
    function automatic int pick_winner(input logic [N-1:0] v, input int ptr, input bit acp);
        if (acp && v[NS-1]) return NS - 1;
        for (int i = 0; i < NS; i++) begin
            int j;
            j = (ptr + i) % NS;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // Record a grant for the wait-bound tracker (from the observed source).
    task automatic note_grant(input logic [N-1:0] v, input int src);
        for (int i = 0; i < NS; i++) begin
            if (i == src || !v[i]) wait_cnt[i] = 0;
            else begin
                wait_cnt[i]++;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
        end
    endtask

    // Run one full transaction on dut0 with i_l2_req_ready held high.
    task automatic serve0(output int obs_src);
        int           exp;
        logic [N-1:0] onehot;
        logic [N-1:0] vsnap;
        obs_src = -1;
        for (int k = 0; k < 20 && !bus0.o_l2_req_valid; k++) tick();
        check("req_valid", 64'(bus0.o_l2_req_valid), 64'(1));
        if (!bus0.o_l2_req_valid) return;
        vsnap   = bus0.i_req_valid;
        exp     = pick_winner(vsnap, m_ptr, 1'b0);
        obs_src = int'(bus0.o_l2_req_src);
        check("grant_src", 64'(bus0.o_l2_req_src), 64'(exp));
        if (exp < 0) return;
        note_grant(vsnap, obs_src);
        onehot      = '0;
        onehot[exp] = 1'b1;
        check("grant_addr", 64'(bus0.o_l2_req_addr), 64'(bus0.i_req_addr[exp]));
        check("grant_write", 64'(bus0.o_l2_req_write), 64'(bus0.i_req_write[exp]));
        check("req_ready", 64'(bus0.o_req_ready), 64'(onehot));
        tick();
        check("wait_quiet", 64'({bus0.o_l2_req_valid, bus0.o_req_ready, bus0.o_resp_valid}), 64'(0));
        bus0.i_l2_resp_data  = {$urandom, $urandom};
        bus0.i_l2_resp_valid = 1'b1;
        #1;
        check("resp_valid", 64'(bus0.o_resp_valid), 64'(onehot));
        check("resp_data", bus0.o_resp_data, bus0.i_l2_resp_data);
        tick();
        bus0.i_l2_resp_valid = 1'b0;
        m_ptr = (exp + 1) % NS;
    endtask

    initial begin
        int           src;
        int           exp;
        int           rr_order [6];
        logic [N-1:0] v;
        logic [CFG_SYSBUS_ADDR_BITS-1:0] held_addr;

        rr_order = '{0, 1, 4, 0, 1, 4};
        for (int i = 0; i < NS; i++) wait_cnt[i] = 0;

        bus1.i_req_valid     = '0;
        bus1.i_req_write     = '0;
        bus1.i_req_addr      = '0;
        bus1.i_l2_req_ready  = 1'b1;
        bus1.i_l2_resp_valid = 1'b0;
        bus1.i_l2_resp_data  = '0;

        // Reset: drive everything active and expect quiet outputs.
        bus0.i_req_valid     = '1;
        bus0.i_req_write     = '1;
        bus0.i_req_addr      = '1;
        bus0.i_l2_req_ready  = 1'b1;
        bus0.i_l2_resp_valid = 1'b1;
        bus0.i_l2_resp_data  = {$urandom, $urandom};
        tick();
        tick();
        check("rst_l2_valid", 64'(bus0.o_l2_req_valid), 64'(0));
        check("rst_ready", 64'(bus0.o_req_ready), 64'(0));
        check("rst_resp_valid", 64'(bus0.o_resp_valid), 64'(0));
        check("rst_resp_data", bus0.o_resp_data, 64'(0));
        check("rst_fields", 64'({bus0.o_l2_req_write, bus0.o_l2_req_addr, bus0.o_l2_req_src}), 64'(0));
        bus0.i_req_valid     = '0;
        bus0.i_req_write     = '0;
        bus0.i_req_addr      = '0;
        bus0.i_l2_resp_valid = 1'b0;
        nrst = 1'b1;
        tick();

        // Single request from slot 2: valid at cycle 0, downstream request at cycle 1.
        bus0.i_req_valid[2] = 1'b1;
        bus0.i_req_addr[2]  = 32'h8000_0040;
        tick();
        check("single_lat", 64'(bus0.o_l2_req_valid), 64'(1));
        check("single_src", 64'(bus0.o_l2_req_src), 64'(2));
        check("single_ready", 64'(bus0.o_req_ready), 64'(5'b00100));
        check("single_addr", 64'(bus0.o_l2_req_addr), 64'(32'h8000_0040));
        serve0(src);
        bus0.i_req_valid = '0;

        // Stray response in IDLE is ignored and starts nothing.
        bus0.i_l2_resp_data  = {$urandom, $urandom};
        bus0.i_l2_resp_valid = 1'b1;
        #1;
        check("stray_resp", 64'(bus0.o_resp_valid), 64'(0));
        tick();
        check("stray_idle", 64'(bus0.o_l2_req_valid), 64'(0));
        bus0.i_l2_resp_valid = 1'b0;

        // Reset pulse returns the pointer to slot 0.
        nrst = 1'b0;
        #1;
        nrst = 1'b1;
        m_ptr = 0;

        // Round-robin over slots 0, 1 and 4 held valid.
        bus0.i_req_valid = 5'b10011;
        for (int i = 0; i < NS; i++) begin
            bus0.i_req_addr[i]  = $urandom;
            bus0.i_req_write[i] = 1'($urandom);
        end
        for (int g = 0; g < 6; g++) begin
            serve0(src);
            check("rr_order", 64'(src), 64'(rr_order[g]));
            if (src >= 0 && src < NS) bus0.i_req_addr[src] = $urandom;
        end
        bus0.i_req_valid = '0;

        // Backpressure: request must stay frozen while the L2 is not ready.
        bus0.i_l2_req_ready = 1'b0;
        bus0.i_req_valid[3] = 1'b1;
        bus0.i_req_write[3] = 1'b1;
        bus0.i_req_addr[3]  = $urandom;
        held_addr           = bus0.i_req_addr[3];
        exp                 = pick_winner(bus0.i_req_valid, m_ptr, 1'b0);
        tick();
        for (int c = 0; c < 6; c++) begin
            check("bp_valid", 64'(bus0.o_l2_req_valid), 64'(1));
            check("bp_fields", 64'({bus0.o_l2_req_write, bus0.o_l2_req_addr, bus0.o_l2_req_src}),
                  64'({1'b1, held_addr, slot_idx_t'(exp)}));
            check("bp_ready", 64'(bus0.o_req_ready), 64'(0));
            tick();
        end
        bus0.i_l2_req_ready = 1'b1;
        #1;
        check("bp_release", 64'(bus0.o_req_ready), 64'(5'b01000));
        tick();
        bus0.i_req_valid[3]  = 1'b0;
        bus0.i_l2_resp_valid = 1'b1;
        #1;
        check("bp_resp", 64'(bus0.o_resp_valid), 64'(5'b01000));
        tick();
        bus0.i_l2_resp_valid = 1'b0;
        m_ptr = 4;

        // Reset while waiting for a response: abort, ignore late response, restart at slot 0.
        bus0.i_req_valid = 5'b00100;
        tick();
        check("ab_src", 64'(bus0.o_l2_req_src), 64'(pick_winner(5'b00100, m_ptr, 1'b0)));
        tick();
        bus0.i_req_valid     = 5'b01010;
        bus0.i_req_addr[1]   = $urandom;
        bus0.i_req_addr[3]   = $urandom;
        nrst                 = 1'b0;
        bus0.i_l2_resp_valid = 1'b1;
        #1;
        check("ab_outputs", 64'({bus0.o_l2_req_valid, bus0.o_req_ready, bus0.o_resp_valid}), 64'(0));
        check("ab_resp_data", bus0.o_resp_data, 64'(0));
        tick();
        nrst  = 1'b1;
        m_ptr = 0;
        #1;
        check("ab_late_resp", 64'(bus0.o_resp_valid), 64'(0));
        bus0.i_l2_resp_valid = 1'b0;
        tick();
        check("ab_regrant", 64'(bus0.o_l2_req_src), 64'(1));
        serve0(src);
        bus0.i_req_valid[1] = 1'b0;

        // Randomized traffic: held requests, random arrivals and departures.
        for (int t = 0; t < 40; t++) begin
            if (bus0.i_req_valid == '0) begin
                v = '0;
                v[$urandom_range(NS - 1, 0)] = 1'b1;
                bus0.i_req_valid = v;
            end
            serve0(src);
            for (int i = 0; i < NS; i++) begin
                if (i == src) begin
                    bus0.i_req_valid[i] = 1'($urandom);
                    bus0.i_req_addr[i]  = $urandom;
                    bus0.i_req_write[i] = 1'($urandom);
                end else if (!bus0.i_req_valid[i] && ($urandom_range(2, 0) == 0)) begin
                    bus0.i_req_valid[i] = 1'b1;
                    bus0.i_req_addr[i]  = $urandom;
                    bus0.i_req_write[i] = 1'($urandom);
                end
            end
        end
        check("max_wait", 64'(max_wait <= NS - 1), 64'(1));
        bus0.i_req_valid = '0;

        // Strict ACP priority on dut1, then fall back to round-robin.
        bus1.i_req_valid = '1;
        for (int i = 0; i < NS; i++) bus1.i_req_addr[i] = $urandom;
        for (int g = 0; g < 5; g++) begin
            if (g == 4) bus1.i_req_valid[NS-1] = 1'b0;
            exp = pick_winner(bus1.i_req_valid, m_ptr1, 1'b1);
            for (int k = 0; k < 20 && !bus1.o_l2_req_valid; k++) tick();
            check("acp_src", 64'(bus1.o_l2_req_src), 64'(exp));
            tick();
            bus1.i_l2_resp_valid = 1'b1;
            #1;
            check("acp_resp", 64'(bus1.o_resp_valid), 64'(5'b00001 << exp));
            tick();
            bus1.i_l2_resp_valid = 1'b0;
            m_ptr1 = (exp + 1) % NS;
        end
        check("acp_fallback_ptr", 64'(m_ptr1), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
